// File: rtl/cmd_arbiter_pkg.sv
// Shared types and constants for the command arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmd_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // The continuation flag always sits at the MSB of a command beat.
    localparam int CONT_FLAG_FROM_MSB = 1;

    function automatic int cont_bit_idx(input int data_width);
        return data_width - CONT_FLAG_FROM_MSB;
    endfunction

endpackage

// File: rtl/cmd_arbiter_skid_buf.sv
// Two-entry registered skid buffer between the arbiter mux and the merged command stream.
// Latency: a beat accepted in cycle N is presented on out_vld in cycle N+1.
// Backpressure: in_rdy is purely registered (not full); head entry holds stable while stalled.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_dat,
    output logic                  out_vld,
    input  logic                  out_rdy
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            cnt;
    logic                  push;
    logic                  pop;

    assign in_rdy  = (cnt != 2'd2);
    assign out_vld = (cnt != 2'd0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin packet arbiter merging NUM_PORTS command streams; CMD_ARBITER_STATS_EN adds per-port packet counters.
// Latency: one cycle from owner acceptance to M_AXIS_CMD_tvalid; back-to-back grants without a bubble.
// Backpressure: owner tready = skid buffer not full; non-owners see tready=0 while a packet is locked.
module cmd_arbiter
    import cmd_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] S_AXIS_CMD_tdata,
    input  logic [NUM_PORTS-1:0]            S_AXIS_CMD_tvalid,
    output logic [NUM_PORTS-1:0]            S_AXIS_CMD_tready,
    output logic [DATA_WIDTH-1:0]           M_AXIS_CMD_tdata,
    output logic                            M_AXIS_CMD_tvalid,
    input  logic                            M_AXIS_CMD_tready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count
);

    localparam int PW       = $clog2(NUM_PORTS);
    localparam int CONT_BIT = cont_bit_idx(DATA_WIDTH);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [PW-1:0]        owner_q;
    logic [PW-1:0]        owner_d;
    logic [PW-1:0]        rr_q;
    logic [PW-1:0]        rr_d;
    logic [PW-1:0]        pick;
    logic [PW-1:0]        pick_next;
    logic                 pick_vld;
    logic [NUM_PORTS-1:0] owner_oh;
    logic [NUM_PORTS-1:0] cand;
    logic [DATA_WIDTH-1:0] owner_dat;
    logic                 owner_vld;
    logic                 locked;
    logic                 skid_in_rdy;
    logic                 push;
    logic                 final_acc;

    assign locked    = (state_q == ARB_LOCKED);
    assign owner_dat = S_AXIS_CMD_tdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign owner_vld = S_AXIS_CMD_tvalid[owner_q];
    assign push      = locked && owner_vld && skid_in_rdy;
    assign final_acc = push && !owner_dat[CONT_BIT];

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // The finishing owner is excluded so an idle-looking owner cannot re-lock itself.
    assign cand = locked ? (S_AXIS_CMD_tvalid & ~owner_oh) : S_AXIS_CMD_tvalid;

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!pick_vld && cand[(int'(rr_q) + k) % NUM_PORTS]) begin
                pick_vld = 1'b1;
                pick     = PW'((int'(rr_q) + k) % NUM_PORTS);
            end
        end
    end

    assign pick_next = (pick == PW'(NUM_PORTS - 1)) ? '0 : pick + 1'b1;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d = ARB_LOCKED;
                    owner_d = pick;
                    rr_d    = pick_next;
                end
            end
            ARB_LOCKED: begin
                if (final_acc) begin
                    if (pick_vld) begin
                        owner_d = pick;
                        rr_d    = pick_next;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant             = locked ? owner_oh : '0;
    assign S_AXIS_CMD_tready = grant & {NUM_PORTS{skid_in_rdy}};

    axis_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .in_dat      (owner_dat),
        .in_vld      (locked && owner_vld),
        .in_rdy      (skid_in_rdy),
        .out_dat     (M_AXIS_CMD_tdata),
        .out_vld     (M_AXIS_CMD_tvalid),
        .out_rdy     (M_AXIS_CMD_tready)
    );

`ifdef CMD_ARBITER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (final_acc && (owner_q == PW'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning the number of command requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning the command beat width; bit DATA_WIDTH-1 is the continuation flag.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the per-port packet counter.
REQ-004 SHALL have port axi_aclk, input, 1, the single clock; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port axi_aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port S_AXIS_CMD_tdata, input, NUM_PORTS*DATA_WIDTH, per-port command beats, port i at slice i.
REQ-007 SHALL have port S_AXIS_CMD_tvalid, input, NUM_PORTS, per-port valid.
REQ-008 SHALL have port S_AXIS_CMD_tready, output, NUM_PORTS, per-port ready.
REQ-009 SHALL have port M_AXIS_CMD_tdata, output, DATA_WIDTH, the merged command stream toward the async command FIFO.
REQ-010 SHALL have port M_AXIS_CMD_tvalid, output, 1, merged valid.
REQ-011 SHALL have port M_AXIS_CMD_tready, input, 1, merged ready.
REQ-012 SHALL have port grant, output, NUM_PORTS, one-hot current packet owner, zero when idle.
REQ-013 SHALL have port pkt_count, output, NUM_PORTS*CNT_WIDTH, per-port completed-packet counts.

Function
REQ-014 SHALL define a packet as consecutive beats from one port, ending at the first beat with tdata[DATA_WIDTH-1]=0; a single beat with bit=0 is a complete packet.
REQ-015 SHALL implement FSM IDLE/LOCKED: IDLE->LOCKED when any tvalid is high, granting that port; LOCKED->IDLE on acceptance of the owner's final beat.
REQ-016 SHALL select the port round-robin, starting the search at the port after the last granted port; after reset the search starts at port 0.
REQ-017 SHALL never interleave beats of different ports; non-owner tready SHALL be 0 while LOCKED.
REQ-018 SHALL register the output through a 2-entry skid buffer: beat accepted in cycle N appears on M_AXIS_CMD_tvalid in N+1; sustained throughput 1 beat/cycle when M_AXIS_CMD_tready=1.
REQ-019 SHALL drive owner tready = skid buffer not full; M_AXIS_CMD_tdata/tvalid SHALL hold stable while tvalid=1 and tready=0.
REQ-020 SHALL allow a grant decision on the cycle the previous final beat is accepted (no idle bubble) when another port is valid.
REQ-021 SHALL treat owner tvalid=0 mid-packet as a stall: stay LOCKED, keep grant, no timeout.
REQ-022 SHALL ignore the continuation flag content otherwise and pass tdata unmodified.

Reset
REQ-023 SHALL on axi_aresetn=0 immediately clear: FSM to IDLE, grant=0, S_AXIS_CMD_tready=0, M_AXIS_CMD_tvalid=0, skid buffer empty, round-robin pointer to port 0, pkt_count=0.
REQ-024 SHALL discard any partially forwarded packet on reset mid-operation; upstream and downstream SHALL be reset together.

Configuration
REQ-025 SHALL compile packet counters in when CMD_ARBITER_STATS_EN is defined: each port count increments by 1 on acceptance of that port's final beat, saturating at 2^CNT_WIDTH-1.
REQ-026 SHALL, without CMD_ARBITER_STATS_EN, tie pkt_count to zero and instantiate no counter logic.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, LOCKED) and the continuation-bit index constant in the shared project package.
REQ-028 SHALL implement the 2-entry skid buffer as sub-module axis_skid_buf, parameterised by DATA_WIDTH.

Verification
REQ-029 SHALL check: ports 0 and 2 each send a 1-beat packet (bit127=0) in the same cycle after reset -> output port 0 beat then port 2 beat, grant 0001 then 0100.
REQ-030 SHALL check: port 1 sends 3 beats (bit127=1,1,0) while port 3 is valid throughout -> all 3 port-1 beats contiguous, port-3 tready=0 until final beat accepted, then port 3 granted next cycle.
REQ-031 SHALL check: M_AXIS_CMD_tready held 0 for 5 cycles mid-packet -> no beat lost or duplicated, owner tready falls after 2 beats buffered, tdata stable.
REQ-032 SHALL check: all 4 ports continuously valid with 1-beat packets for 16 packets -> grant order 0,1,2,3 repeated, 4 packets each, 1 beat/cycle.
REQ-033 SHALL check: axi_aresetn asserted after beat 2 of a 4-beat packet -> all outputs zero in the same cycle, after release next grant goes to lowest valid port from 0.
REQ-034 SHALL check with CMD_ARBITER_STATS_EN, CNT_WIDTH=4: port 0 sends 20 packets -> pkt_count[3:0]=15, saturated; without the macro pkt_count=0.
